// File: rtl/range_presence_filter.sv
// Debounced, hysteretic presence detector fed by ultrasonic distance samples.
// A sliding window of hit bits (distance below NEAR_TH) drives a FILL/ABSENT/PRESENT
// state machine. A stale state is entered when no sample arrives for TIMEOUT_CYC cycles.
module range_presence_filter #(
    parameter int unsigned DIST_W      = 22,
    parameter int unsigned DEPTH       = 10,
    parameter int unsigned NEAR_TH     = 65536,
    parameter int unsigned ON_COUNT    = 8,
    parameter int unsigned OFF_COUNT   = 2,
    parameter int unsigned TIMEOUT_CYC = 25000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           sample_valid,
    input  logic [DIST_W-1:0]              distance,
    output logic                           present,
    output logic                           present_rise,
    output logic                           present_fall,
    output logic [$clog2(DEPTH+1)-1:0]     hit_count,
    output logic                           window_full,
    output logic                           stale
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StFill, StAbsent, StPresent, StStale} state_e;

    state_e             state_q, state_d;
    logic [DEPTH-1:0]   window_q, window_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic               window_full_q, window_full_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               present_q, present_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               stale_q, stale_d;

    logic               accepted;
    logic               hit;
    logic               oldest;
    logic               timeout;
    logic [CNT_W-1:0]   count_next;

    assign accepted   = sample_valid & enable;
    assign hit        = distance < DIST_W'(NEAR_TH);
    // Oldest bit only leaves the window once the window is full.
    assign oldest     = window_full_q & window_q[DEPTH-1];
    assign count_next = hit_count_q + CNT_W'(hit) - CNT_W'(oldest);
    // Fires on the edge where the timer would reach TIMEOUT_CYC; a sample wins the race.
    assign timeout    = enable & ~accepted & (state_q != StStale)
                        & (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    // Inactivity timer: cleared by samples, counts while enabled, saturates.
    always_comb begin
        timer_d = timer_q;
        if (accepted) begin
            timer_d = '0;
        end else if (enable && (timer_q != TMR_W'(TIMEOUT_CYC))) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // Window update, state transitions and edge pulses.
    always_comb begin
        state_d       = state_q;
        window_d      = window_q;
        hit_count_d   = hit_count_q;
        fill_d        = fill_q;
        window_full_d = window_full_q;
        rise_d        = 1'b0;
        fall_d        = 1'b0;

        if (accepted) begin
            if (state_q == StStale) begin
                // The sample that ends a stale period is the first of a fresh fill.
                window_d      = {{(DEPTH-1){1'b0}}, hit};
                hit_count_d   = CNT_W'(hit);
                fill_d        = CNT_W'(1);
                window_full_d = 1'b0;
                state_d       = StFill;
            end else begin
                window_d    = {window_q[DEPTH-2:0], hit};
                hit_count_d = count_next;
                if (!window_full_q) begin
                    fill_d = fill_q + CNT_W'(1);
                end
                case (state_q)
                    StFill: begin
                        if (fill_q == CNT_W'(DEPTH - 1)) begin
                            window_full_d = 1'b1;
                            if (count_next >= CNT_W'(ON_COUNT)) begin
                                state_d = StPresent;
                                rise_d  = 1'b1;
                            end else begin
                                state_d = StAbsent;
                            end
                        end
                    end
                    StAbsent: begin
                        if (count_next >= CNT_W'(ON_COUNT)) begin
                            state_d = StPresent;
                            rise_d  = 1'b1;
                        end
                    end
                    StPresent: begin
                        if (count_next <= CNT_W'(OFF_COUNT)) begin
                            state_d = StAbsent;
                            fall_d  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (timeout) begin
            state_d       = StStale;
            window_d      = '0;
            hit_count_d   = '0;
            fill_d        = '0;
            window_full_d = 1'b0;
            fall_d        = (state_q == StPresent);
        end

        present_d = (state_d == StPresent);
        stale_d   = (state_d == StStale);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFill;
            window_q      <= '0;
            hit_count_q   <= '0;
            fill_q        <= '0;
            window_full_q <= 1'b0;
            timer_q       <= '0;
            present_q     <= 1'b0;
            rise_q        <= 1'b0;
            fall_q        <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            window_q      <= window_d;
            hit_count_q   <= hit_count_d;
            fill_q        <= fill_d;
            window_full_q <= window_full_d;
            timer_q       <= timer_d;
            present_q     <= present_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            stale_q       <= stale_d;
        end
    end

    assign present      = present_q;
    assign present_rise = rise_q;
    assign present_fall = fall_q;
    assign hit_count    = hit_count_q;
    assign window_full  = window_full_q;
    assign stale        = stale_q;

endmodule

// File: doc/range_presence_filter.md
Name: range_presence_filter

Overview:
- Turns raw ultrasonic distance samples into a debounced, hysteretic presence flag.
- Generalises the fixed 10-sample "within range" bit-window used on the board. Adds a parametrised depth and threshold, separate on/off counts, edge pulses and a stale-sensor timeout.
- Sits between the hc_sr04 ranging block (distance and sample-valid pulse) and the lamp control logic / LEDs.

Parameters:
- DIST_W, 22, width of the distance input.
- DEPTH, 10, sliding-window length in samples; must be >= 2.
- NEAR_TH, 65536, a sample is a hit when distance < NEAR_TH (strict).
- ON_COUNT, 8, hits in a full window needed to assert presence; OFF_COUNT < ON_COUNT <= DEPTH.
- OFF_COUNT, 2, presence deasserts when hits <= OFF_COUNT; must be >= 0.
- TIMEOUT_CYC, 25000000, clock cycles without an accepted sample before the stale state; must be >= 2.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, samples are ignored and the timeout timer holds.
- sample_valid  in  1  one-cycle pulse; distance is valid in this cycle.
- distance  in  DIST_W  measured echo width from the ranging block.
- present  out  1  filtered presence.
- present_rise  out  1  one-cycle pulse on a 0->1 transition of present.
- present_fall  out  1  one-cycle pulse on a 1->0 transition of present.
- hit_count  out  $clog2(DEPTH+1)  hits currently in the window.
- window_full  out  1  DEPTH samples collected since reset or since the last stale event.
- stale  out  1  high while in STALE.

Behaviour:
- Reset (rst=1 at posedge):
  - window bits, hit_count, fill counter and timer all go to 0.
  - present, present_rise, present_fall, window_full and stale all go to 0.
  - state goes to FILL.
  - Reset mid-window discards all samples.
- Accepted sample = sample_valid & enable.
- On an accepted sample:
  - hit = (distance < NEAR_TH); distance == NEAR_TH is a miss.
  - hit shifts into a DEPTH-bit window.
  - Once the window is full, the oldest bit drops out.
  - hit_count_next = hit_count + hit - (window_full ? oldest : 0). It never exceeds DEPTH and never underflows.
- Latency: hit_count, window_full, present and the edge pulses all update on the clock edge following the cycle in which sample_valid is high (1-cycle latency).
- State machine (states FILL, ABSENT, PRESENT, STALE):
  - FILL: present=0. On the accepted sample that makes the fill count reach DEPTH, window_full goes to 1. In the same update, go to PRESENT if hit_count_next >= ON_COUNT (with a rise pulse), else go to ABSENT.
  - ABSENT: go to PRESENT when hit_count_next >= ON_COUNT after an accepted sample; present_rise fires on the same edge that present goes to 1.
  - PRESENT: go to ABSENT when hit_count_next <= OFF_COUNT; present_fall fires on the same edge that present goes to 0. Counts strictly between OFF_COUNT and ON_COUNT hold the current state (hysteresis).
  - STALE: stale=1, present=0, window cleared, hit_count=0, window_full=0. The next accepted sample leaves STALE, becomes sample 1 of a new fill, and the block goes to FILL; stale clears on that edge.
- Timeout:
  - The timer resets to 0 on every accepted sample.
  - Otherwise it increments while enable=1, saturating at TIMEOUT_CYC.
  - When the timer reaches TIMEOUT_CYC in FILL, ABSENT or PRESENT, the block goes to STALE on that edge.
  - If it was in PRESENT, present_fall pulses on that edge.
  - An accepted sample in the same cycle the timeout would fire takes priority: the sample is processed and no stale event occurs.
- enable=0: sample_valid is ignored, the timer holds its value, state and outputs hold, and the pulses stay 0.
- present_rise and present_fall are never high together and never high for more than one cycle.
- All outputs are registered; no combinational path from input to output.

Test Plan:
Common bench parameters: DEPTH=4, ON_COUNT=3, OFF_COUNT=1, NEAR_TH=1000, TIMEOUT_CYC=100.
1. Fill and assert:
   - Stimulus: reset, then 4 samples of distance=500 spaced 5 cycles apart.
   - Response: hit_count steps 1,2,3,4. window_full and present go to 1 one cycle after the 4th sample_valid. present_rise is high for exactly that one cycle. No rise occurs before the window is full.
2. Hysteresis release:
   - Stimulus: from test 1, send samples 2000, 2000, 2000.
   - Response: hit_count steps 3, 2, 1. present stays 1 at counts 3 and 2, and falls at count 1 with a single present_fall pulse.
3. Threshold boundary:
   - Stimulus: 4 samples of exactly 1000 after reset, then 999.
   - Response: hit_count stays 0 through the 4 samples and present=0 (state ABSENT). The 999 sample gives hit_count=1.
4. Stale timeout:
   - Stimulus: while present=1, send no samples for 100 cycles.
   - Response: stale=1, present_fall pulses once, hit_count=0, window_full=0. The next sample of 500 clears stale and gives hit_count=1 with present=0.
5. Timeout race:
   - Stimulus: assert sample_valid in the exact cycle the timer would hit 100.
   - Response: stale stays 0, the sample is counted, and the timer restarts from 0.
6. Enable and mid-fill reset:
   - Stimulus: with enable=0, pulse sample_valid 5 times; then set enable=1, send 2 hits, then assert rst for 1 cycle.
   - Response: the 5 gated samples leave hit_count=0. The 2 hits give hit_count=2. The reset returns every output to 0 and the state to FILL.
